// File: rtl/spike_synapse_tx_if.sv
// Handshake/data bundle between a presynaptic transmitter and whatever drives or observes it.
// The master side supplies spikes and weight updates; the slave side is the transmitter.
interface spike_synapse_tx_if;
  logic        pre_spike;
  logic        w_valid;
  logic [15:0] w_data;
  logic        w_ready;
  logic [15:0] inspk;
  logic [3:0]  frame_cnt;
  logic        busy;
  logic        dropped;

  modport master (
    output pre_spike, w_valid, w_data,
    input  w_ready, inspk, frame_cnt, busy, dropped
  );

  modport slave (
    input  pre_spike, w_valid, w_data,
    output w_ready, inspk, frame_cnt, busy, dropped
  );
endinterface

// File: rtl/spike_synapse_tx.sv
// Presynaptic transmitter: buffers spike edges and drives the weight for HOLD cycles in its frame slot.
// Optional short-term depression is enabled by defining SYN_TX_DEPRESS_EN.
module spike_synapse_tx #(
  parameter logic [3:0]  SLOT        = 4'd0,
  parameter int          HOLD        = 4,
  parameter logic [15:0] INIT_WEIGHT = 16'd13
) (
  input  logic             clk,
  input  logic             reset,
  spike_synapse_tx_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT_SLOT, DRIVE} state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLD - 1);

  state_t      state, state_nxt;
  logic [3:0]  frame_cnt_q;
  logic        prev;
  logic [1:0]  pend, pend_nxt;
  logic [3:0]  hold, hold_nxt;
  logic [15:0] weight;
  logic [15:0] inspk_q, inspk_nxt;
  logic        dropped_q, dropped_nxt;
  logic        spike_evt;
  logic        dequeue;
  logic        w_ready_c;
  logic [15:0] drive_val;

  assign spike_evt = bus.pre_spike & ~prev;
  assign w_ready_c = (state != DRIVE);
  assign dequeue   = (state == DRIVE) && (hold == 4'd0);

  assign bus.w_ready   = w_ready_c;
  assign bus.inspk     = inspk_q;
  assign bus.frame_cnt = frame_cnt_q;
  assign bus.busy      = (state != IDLE);
  assign bus.dropped   = dropped_q;

  // An edge that coincides with a dequeue simply takes the freed slot.
  always_comb begin
    pend_nxt    = pend;
    dropped_nxt = 1'b0;
    if (spike_evt && !dequeue) begin
      if (pend == 2'd2) dropped_nxt = 1'b1;
      else              pend_nxt    = pend + 2'd1;
    end else if (!spike_evt && dequeue) begin
      pend_nxt = pend - 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    inspk_nxt = inspk_q;
    case (state)
      IDLE: begin
        if (pend != 2'd0) state_nxt = WAIT_SLOT;
      end
      WAIT_SLOT: begin
        if (frame_cnt_q == SLOT) begin
          state_nxt = DRIVE;
          inspk_nxt = drive_val;
          hold_nxt  = HOLD_INIT;
        end
      end
      DRIVE: begin
        if (hold == 4'd0) begin
          inspk_nxt = '0;
          state_nxt = (pend_nxt != 2'd0) ? WAIT_SLOT : IDLE;
        end else begin
          hold_nxt = hold - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      frame_cnt_q <= '0;
      prev        <= 1'b0;
      pend        <= '0;
      hold        <= '0;
      inspk_q     <= '0;
      dropped_q   <= 1'b0;
      weight      <= INIT_WEIGHT;
    end else begin
      state       <= state_nxt;
      frame_cnt_q <= frame_cnt_q + 4'd1;
      prev        <= bus.pre_spike;
      pend        <= pend_nxt;
      hold        <= hold_nxt;
      inspk_q     <= inspk_nxt;
      dropped_q   <= dropped_nxt;
      if (bus.w_valid && w_ready_c) weight <= bus.w_data;
    end
  end

`ifdef SYN_TX_DEPRESS_EN
  // Consecutive-burst count; any return to IDLE restores full strength.
  logic [1:0] consec;

  assign drive_val = weight >> consec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      consec <= '0;
    end else if (dequeue) begin
      if (state_nxt == IDLE)      consec <= '0;
      else if (consec != 2'd3)    consec <= consec + 2'd1;
    end
  end
`else
  assign drive_val = weight;
`endif

endmodule

// File: tb/tb_spike_synapse_tx.sv
// Self-checking bench for spike_synapse_tx: per-cycle comparison against a burst-level model
// plus directed scenarios with hand-computed burst values.
module tb_spike_synapse_tx;

  localparam logic [3:0]  SLOT   = 4'd0;
  localparam int          HOLD   = 4;
  localparam logic [15:0] INIT_W = 16'd13;
`ifdef SYN_TX_DEPRESS_EN
  localparam bit DEPRESS = 1'b1;
`else
  localparam bit DEPRESS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  spike_synapse_tx_if bus();

  spike_synapse_tx #(
    .SLOT        (SLOT),
    .HOLD        (HOLD),
    .INIT_WEIGHT (INIT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit compareEn = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  // Model: pending spikes, an armed flag (busy), and a remaining-drive-cycles counter.
  int mFrame, mPend, mLeft, mConsec, mVal, mWeight;
  bit mPrev, mArmed, mDropped;

  always @(posedge clk or negedge reset) begin : modelStep
    bit ev, last, driving;
    int pendAfter;
    if (!reset) begin
      mFrame = 0; mPend = 0; mLeft = 0; mConsec = 0; mVal = 0;
      mWeight = INIT_W; mPrev = 1'b0; mArmed = 1'b0; mDropped = 1'b0;
    end else begin
      ev        = bus.pre_spike && !mPrev;
      driving   = (mLeft > 0);
      last      = (mLeft == 1);
      mDropped  = 1'b0;
      pendAfter = mPend;
      if (ev && !last) begin
        if (mPend == 2) mDropped = 1'b1;
        else            pendAfter = mPend + 1;
      end else if (!ev && last) begin
        pendAfter = mPend - 1;
      end
      if (last) begin
        mLeft   = 0;
        mVal    = 0;
        mArmed  = (pendAfter > 0);
        mConsec = (pendAfter > 0) ? ((mConsec < 3) ? mConsec + 1 : 3) : 0;
      end else if (driving) begin
        mLeft = mLeft - 1;
      end else if (mArmed && mFrame == SLOT) begin
        mLeft = HOLD;
        mVal  = DEPRESS ? (mWeight >> mConsec) : mWeight;
      end else if (!mArmed && mPend > 0) begin
        mArmed = 1'b1;
      end
      if (bus.w_valid && !driving) mWeight = bus.w_data;
      mPend  = pendAfter;
      mPrev  = bus.pre_spike;
      mFrame = (mFrame + 1) % 16;
    end
  end

  always @(negedge clk) begin
    if (compareEn) begin
      checkOutput("inspk",     bus.inspk,     mVal);
      checkOutput("busy",      bus.busy,      mArmed);
      checkOutput("w_ready",   bus.w_ready,   (mLeft == 0));
      checkOutput("frame_cnt", bus.frame_cnt, mFrame);
      checkOutput("dropped",   bus.dropped,   mDropped);
    end
  end

  // Burst log for the directed scenarios.
  int burstVals[$];
  int burstLens[$];
  int burstStart[$];
  int busyFall[$];
  int dropCount = 0;
  int curLen = 0;
  logic [15:0] lastIn = '0;
  logic lastBusy = 1'b0;

  always @(negedge clk) begin
    if (bus.inspk != 16'd0) begin
      if (lastIn == 16'd0) begin
        burstVals.push_back(int'(bus.inspk));
        burstStart.push_back(int'(bus.frame_cnt));
        curLen = 0;
      end
      curLen++;
    end else if (lastIn != 16'd0) begin
      burstLens.push_back(curLen);
    end
    if (lastBusy && !bus.busy) busyFall.push_back(int'(bus.frame_cnt));
    if (bus.dropped) dropCount++;
    lastIn   = bus.inspk;
    lastBusy = bus.busy;
  end

  task automatic clearLog();
    burstVals.delete();
    burstLens.delete();
    burstStart.delete();
    busyFall.delete();
    dropCount = 0;
  endtask

  task automatic applyStimulus(input bit spike, input bit wv, input logic [15:0] wd, input int cycles);
    bus.pre_spike = spike;
    bus.w_valid   = wv;
    bus.w_data    = wd;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitFrame(input int f);
    int n = 0;
    @(negedge clk);
    while (int'(bus.frame_cnt) != f && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (int'(bus.frame_cnt) != f) timeoutFail("waitFrame");
  endtask

  task automatic waitIdle();
    int n = 0;
    while (bus.busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) timeoutFail("waitIdle");
  endtask

  task automatic waitDrive();
    int n = 0;
    @(negedge clk);
    while (bus.inspk == 16'd0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (bus.inspk == 16'd0) timeoutFail("waitDrive");
  endtask

  task automatic pulseAtFrame(input int f);
    waitFrame(f);
    applyStimulus(1'b1, 1'b0, 16'd0, 1);
    applyStimulus(1'b0, 1'b0, 16'd0, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int prevFrame;
    int exp6 [4];
    bus.pre_spike = 1'b0;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_inspk",   bus.inspk,     0);
    checkOutput("rst_busy",    bus.busy,      0);
    checkOutput("rst_frame",   bus.frame_cnt, 0);
    checkOutput("rst_w_ready", bus.w_ready,   1);
    checkOutput("rst_dropped", bus.dropped,   0);
    reset = 1'b1;
    compareEn = 1'b1;

    // Quiet input: counter runs and wraps, nothing is driven.
    prevFrame = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prevFrame == 15) checkOutput("t1_wrap", bus.frame_cnt, 0);
      prevFrame = int'(bus.frame_cnt);
    end
    checkOutput("t1_frame40", bus.frame_cnt, 8);
    checkOutput("t1_inspk",   bus.inspk,     0);
    checkOutput("t1_busy",    bus.busy,      0);
    clearLog();

    // Single spike at frame 5.
    waitFrame(5);
    applyStimulus(1'b1, 1'b0, 16'd0, 2);
    applyStimulus(1'b0, 1'b0, 16'd0, 30);
    checkOutput("t2_nbursts", burstVals.size(), 1);
    if (burstVals.size() == 1) begin
      checkOutput("t2_value", burstVals[0],  13);
      checkOutput("t2_len",   burstLens[0],  4);
      checkOutput("t2_start", burstStart[0], 1);
    end
    checkOutput("t2_busyfalls", busyFall.size(), 1);
    if (busyFall.size() == 1) checkOutput("t2_busyfall_frame", busyFall[0], 5);
    clearLog();

    // Three edges in one frame: two bursts, one drop.
    waitFrame(2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'd0, 1);
      applyStimulus(1'b0, 1'b0, 16'd0, 1);
    end
    applyStimulus(1'b0, 1'b0, 16'd0, 60);
    checkOutput("t3_drops",   dropCount,        1);
    checkOutput("t3_nbursts", burstVals.size(), 2);
    if (burstVals.size() == 2) begin
      checkOutput("t3_first",  burstVals[0], 13);
      checkOutput("t3_second", burstVals[1], DEPRESS ? 6 : 13);
    end
    clearLog();

    // Weight write during DRIVE waits for the burst to finish.
    waitFrame(3);
    applyStimulus(1'b1, 1'b0, 16'd0, 1);
    applyStimulus(1'b0, 1'b0, 16'd0, 1);
    waitDrive();
    checkOutput("t4_ready_in_drive", bus.w_ready, 0);
    bus.w_valid = 1'b1;
    bus.w_data  = 16'd20;
    for (int n = 0; n < 20 && !bus.w_ready; n++) @(negedge clk);
    checkOutput("t4_ready_after", bus.w_ready, 1);
    @(negedge clk);
    bus.w_valid = 1'b0;
    waitIdle();
    pulseAtFrame(6);
    applyStimulus(1'b0, 1'b0, 16'd0, 30);
    checkOutput("t4_nbursts", burstVals.size(), 2);
    if (burstVals.size() == 2) begin
      checkOutput("t4_current", burstVals[0], 13);
      checkOutput("t4_next",    burstVals[1], 20);
    end
    clearLog();

    // Reset asserted mid-burst with hold at 2.
    pulseAtFrame(8);
    waitDrive();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t5_async_inspk", bus.inspk, 0);
    checkOutput("t5_async_busy",  bus.busy,  0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    clearLog();
    applyStimulus(1'b0, 1'b0, 16'd0, 40);
    checkOutput("t5_no_stale_burst", burstVals.size(), 0);
    pulseAtFrame(4);
    applyStimulus(1'b0, 1'b0, 16'd0, 30);
    checkOutput("t5_nbursts", burstVals.size(), 1);
    if (burstVals.size() == 1) checkOutput("t5_weight_restored", burstVals[0], 13);
    clearLog();

    // Paced spikes one per frame, then a gap.
    exp6 = DEPRESS ? '{13, 6, 3, 13} : '{13, 13, 13, 13};
    waitIdle();
    for (int i = 0; i < 3; i++) pulseAtFrame(2);
    waitIdle();
    applyStimulus(1'b0, 1'b0, 16'd0, 32);
    pulseAtFrame(2);
    applyStimulus(1'b0, 1'b0, 16'd0, 30);
    checkOutput("t6_nbursts", burstVals.size(), 4);
    if (burstVals.size() == 4) begin
      for (int i = 0; i < 4; i++) checkOutput($sformatf("t6_burst%0d", i), burstVals[i], exp6[i]);
    end

    compareEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
